// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i memory arbiter.
//  arb_state_e : arbiter FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//  gnt_e       : which requester owns the current transaction
//  BE_ALL      : full-word byte enable used for every instruction fetch
//  CNT_W       : width of the read-latency counter (covers LATENCY 1..4)
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

  localparam logic [3:0] BE_ALL = 4'hF;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/rv32i_mem_arb_pick.sv
// Combinational winner selection for the rv32i memory arbiter.
// Data requests normally win; after MAX_STREAK consecutive data grants
// taken while a fetch was waiting, the fetch gets the next grant.
// Ports:
//  if_req, d_req : raw requests from the fetch and load/store ports
//  streak        : current count of data grants won against a pending fetch
//  any_req       : at least one request is present
//  gnt           : winner (only meaningful when any_req is high)
//  streak_next   : streak value to store if this grant is taken
module rv32i_mem_arb_pick
  import rv32i_pkg::*;
#(
  parameter int MAX_STREAK = 4,
  parameter int STREAK_W   = 3
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                any_req,
  output gnt_e                gnt,
  output logic [STREAK_W-1:0] streak_next
);

  // NOTE: every output gets a default before any branch, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    any_req     = if_req | d_req;
    gnt         = GNT_D;
    streak_next = streak;
    if (d_req && if_req) begin
      if (streak < STREAK_W'(MAX_STREAK)) begin
        gnt         = GNT_D;
        streak_next = streak + STREAK_W'(1);
      end else begin
        gnt         = GNT_IF;
        streak_next = '0;
      end
    end else if (d_req) begin
      // Nobody was starved by this grant, so the streak starts over.
      gnt         = GNT_D;
      streak_next = '0;
    end else if (if_req) begin
      gnt         = GNT_IF;
      streak_next = '0;
    end
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port synchronous word RAM between the rv32i fetch port
// and load/store port. One transaction outstanding at a time; data side has
// priority with an anti-starvation limit for fetch. All mem_* and ready
// outputs are registered, as are both read-data returns.
// Ports:
//  clk, reset_n                 : clock, asynchronous active-low reset
//  if_req/if_addr               : fetch request, held until if_ready
//  if_ready/if_rdata            : one-cycle completion pulse + fetched word
//  d_req/d_we/d_addr/d_wdata/d_be : load/store request, held until d_ready
//  d_ready/d_rdata/d_err        : completion pulse, loaded word, be==0 error
//  mem_en/mem_we/mem_be/mem_addr/mem_wdata : RAM command (one mem_en cycle)
//  mem_rdata                    : RAM read data, valid LATENCY cycles after mem_en
// Timing: request seen in IDLE in cycle T -> mem_en in T+1 -> ready in
// T+LATENCY+2. A data request with d_be==0 skips the RAM: ready+err in T+1.
module rv32i_mem_arbiter
  import rv32i_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_AW     = 14,
  parameter int LATENCY    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);

  arb_state_e          state_q, state_nxt;
  gnt_e                gnt_q, gnt_nxt;
  logic                we_q, we_nxt;
  logic [STREAK_W-1:0] streak_q, streak_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;

  logic                mem_en_nxt, mem_we_nxt;
  logic [3:0]          mem_be_nxt;
  logic [MEM_AW-1:0]   mem_addr_nxt;
  logic [31:0]         mem_wdata_nxt;
  logic                if_ready_nxt, d_ready_nxt, d_err_nxt;
  logic                cap_if, cap_d;

  logic                pick_any;
  gnt_e                pick_gnt;
  logic [STREAK_W-1:0] pick_streak;

  // Byte-offset and above-RAM address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[ADDR_W-1:MEM_AW+2], if_addr[1:0],
                              d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

  rv32i_mem_arb_pick #(
    .MAX_STREAK (MAX_STREAK),
    .STREAK_W   (STREAK_W)
  ) u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .streak      (streak_q),
    .any_req     (pick_any),
    .gnt         (pick_gnt),
    .streak_next (pick_streak)
  );

  // Next-state and next-output logic. Outputs are computed one cycle early
  // and registered, so each one is valid in the state it belongs to.
  always_comb begin
    state_nxt     = state_q;
    gnt_nxt       = gnt_q;
    we_nxt        = we_q;
    streak_nxt    = streak_q;
    cnt_nxt       = cnt_q;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_be_nxt    = '0;
    mem_addr_nxt  = '0;
    mem_wdata_nxt = '0;
    if_ready_nxt  = 1'b0;
    d_ready_nxt   = 1'b0;
    d_err_nxt     = 1'b0;
    cap_if        = 1'b0;
    cap_d         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_nxt    = pick_gnt;
          streak_nxt = pick_streak;
          if (pick_gnt == GNT_D) begin
            we_nxt = d_we;
            if (d_be == 4'b0000) begin
              // Misaligned access reported by the core: never touch the RAM.
              state_nxt   = ST_RESP;
              d_ready_nxt = 1'b1;
              d_err_nxt   = 1'b1;
            end else begin
              state_nxt     = ST_ISSUE;
              mem_en_nxt    = 1'b1;
              mem_we_nxt    = d_we;
              mem_be_nxt    = d_be;
              mem_addr_nxt  = d_addr[MEM_AW+1:2];
              mem_wdata_nxt = d_wdata;
            end
          end else begin
            we_nxt       = 1'b0;
            state_nxt    = ST_ISSUE;
            mem_en_nxt   = 1'b1;
            mem_be_nxt   = BE_ALL;
            mem_addr_nxt = if_addr[MEM_AW+1:2];
          end
        end
      end
      ST_ISSUE: begin
        // The first WAIT cycle is one cycle after mem_en.
        state_nxt = ST_WAIT;
        cnt_nxt   = CNT_W'(1);
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(LATENCY)) begin
          state_nxt = ST_RESP;
          cnt_nxt   = '0;
          if (gnt_q == GNT_IF) begin
            cap_if       = 1'b1;
            if_ready_nxt = 1'b1;
          end else begin
            cap_d       = ~we_q;
            d_ready_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the read-data returns are ordinary registers, not a memory
      // array, so they are cleared along with the rest of the state.
      state_q   <= ST_IDLE;
      gnt_q     <= GNT_IF;
      we_q      <= 1'b0;
      streak_q  <= '0;
      cnt_q     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_nxt;
      gnt_q     <= gnt_nxt;
      we_q      <= we_nxt;
      streak_q  <= streak_nxt;
      cnt_q     <= cnt_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_be    <= mem_be_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_ready  <= if_ready_nxt;
      d_ready   <= d_ready_nxt;
      d_err     <= d_err_nxt;
      if (cap_if) if_rdata <= mem_rdata;
      if (cap_d)  d_rdata  <= mem_rdata;
    end
  end

endmodule
